// File: rtl/t_predictor.sv
// Linear temperature predictor: projects T_cur forward H steps by dT with
// saturation, and reports threshold crossings found along the way.
module t_predictor (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic signed [7:0] T_cur,
    input  logic signed [7:0] dT_in,
    input  logic              dt_valid,
    input  logic [3:0]        horizon,
    input  logic signed [7:0] T_hi,
    input  logic signed [7:0] T_lo,
    output logic signed [7:0] T_pred,
    output logic              pred_valid,
    output logic              busy,
    output logic              cross_hi,
    output logic              cross_lo,
    output logic [4:0]        steps_to_cross,
    output logic              sat,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [4:0] NO_CROSS = 5'd31;

    state_t state, state_next;

    logic signed [7:0] acc, d, th_hi, th_lo;
    logic [3:0]        h, k;
    logic              trk_hi, trk_lo, trk_sat;
    logic [4:0]        trk_steps;

    logic signed [8:0] sum;
    logic signed [7:0] step_acc;
    logic              step_clamp, step_hi, step_lo, last_step;
    logic [3:0]        k_next;
    logic              nxt_hi, nxt_lo, nxt_sat;
    logic [4:0]        nxt_steps;
    logic              cap_hi, cap_lo;
    logic [4:0]        cap_steps;

    // One accumulation step: 9-bit sum clamped back into the Q7.0 range,
    // then merged into the running crossing/saturation tracking.
    always_comb begin
        sum        = {acc[7], acc} + {d[7], d};
        step_acc   = sum[7:0];
        step_clamp = 1'b0;
        if (sum > 9'sd127) begin
            step_acc   = 8'sd127;
            step_clamp = 1'b1;
        end else if (sum < -9'sd128) begin
            step_acc   = -8'sd128;
            step_clamp = 1'b1;
        end
        k_next    = k + 4'd1;
        last_step = (k_next == h);
        step_hi   = (step_acc >= th_hi);
        step_lo   = (step_acc <= th_lo);
        nxt_hi    = trk_hi | step_hi;
        nxt_lo    = trk_lo | step_lo;
        nxt_sat   = trk_sat | step_clamp;
        nxt_steps = trk_steps;
        if ((trk_steps == NO_CROSS) && (step_hi || step_lo))
            nxt_steps = {1'b0, k_next};
    end

    always_comb begin
        cap_hi    = (T_cur >= T_hi);
        cap_lo    = (T_cur <= T_lo);
        cap_steps = (cap_hi || cap_lo) ? 5'd0 : NO_CROSS;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (init) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (dt_valid) state_next = (horizon == 4'd0) ? DONE : ACCUM;
                ACCUM:   if (last_step) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        pred_valid = (state == DONE);
    end

    // Datapath and result registers; results only change on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc            <= '0;
            d              <= '0;
            h              <= '0;
            k              <= '0;
            th_hi          <= '0;
            th_lo          <= '0;
            trk_hi         <= 1'b0;
            trk_lo         <= 1'b0;
            trk_sat        <= 1'b0;
            trk_steps      <= NO_CROSS;
            T_pred         <= '0;
            cross_hi       <= 1'b0;
            cross_lo       <= 1'b0;
            sat            <= 1'b0;
            steps_to_cross <= NO_CROSS;
            overrun        <= 1'b0;
        end else if (init) begin
            acc            <= '0;
            d              <= '0;
            h              <= '0;
            k              <= '0;
            trk_hi         <= 1'b0;
            trk_lo         <= 1'b0;
            trk_sat        <= 1'b0;
            trk_steps      <= NO_CROSS;
            T_pred         <= '0;
            cross_hi       <= 1'b0;
            cross_lo       <= 1'b0;
            sat            <= 1'b0;
            steps_to_cross <= NO_CROSS;
            overrun        <= 1'b0;
        end else begin
            if (dt_valid && (state != IDLE))
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (dt_valid) begin
                        acc       <= T_cur;
                        d         <= dT_in;
                        h         <= horizon;
                        k         <= '0;
                        th_hi     <= T_hi;
                        th_lo     <= T_lo;
                        trk_hi    <= cap_hi;
                        trk_lo    <= cap_lo;
                        trk_sat   <= 1'b0;
                        trk_steps <= cap_steps;
                        if (horizon == 4'd0) begin
                            T_pred         <= T_cur;
                            cross_hi       <= cap_hi;
                            cross_lo       <= cap_lo;
                            sat            <= 1'b0;
                            steps_to_cross <= cap_steps;
                        end
                    end
                end
                ACCUM: begin
                    acc       <= step_acc;
                    k         <= k_next;
                    trk_hi    <= nxt_hi;
                    trk_lo    <= nxt_lo;
                    trk_sat   <= nxt_sat;
                    trk_steps <= nxt_steps;
                    if (last_step) begin
                        T_pred         <= step_acc;
                        cross_hi       <= nxt_hi;
                        cross_lo       <= nxt_lo;
                        sat            <= nxt_sat;
                        steps_to_cross <= nxt_steps;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
